// File: rtl/costas_acq_ctrl_if.sv
// Control/status bundle between the Costas acquisition controller and its host.
// master drives the requests and the lock flag; slave is the controller itself.
interface costas_acq_ctrl_if;
    logic        start_i;
    logic        abort_i;
    logic        locked_i;
    logic [31:0] phase_nco_o;
    logic        enable_o;
    logic [7:0]  step_idx_o;
    logic        acq_o;
    logic        track_o;
    logic        fail_o;

    modport master (
        output start_i, abort_i, locked_i,
        input  phase_nco_o, enable_o, step_idx_o, acq_o, track_o, fail_o
    );

    modport slave (
        input  start_i, abort_i, locked_i,
        output phase_nco_o, enable_o, step_idx_o, acq_o, track_o, fail_o
    );
endinterface

// File: rtl/costas_acq_ctrl.sv
// Frequency-acquisition controller: sweeps the NCO increment around a nominal
// carrier until the Costas loop qualifies lock, then tracks and re-acquires on loss.
module costas_acq_ctrl #(
    parameter logic [31:0] F_CENTER   = 32'h1000_0000,
    parameter logic [31:0] STEP_INC   = 32'h0010_0000,
    parameter int          N_STEPS    = 4,
    parameter int          SETTLE_CYC = 300,
    parameter int          DWELL_CYC  = 1024,
    parameter int          LOCK_QUAL  = 64,
    parameter int          LOSS_CYC   = 256,
    parameter int          MAX_SWEEPS = 4
) (
    input  logic              clk_main,
    input  logic              rst,
    costas_acq_ctrl_if.slave  acqBus
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(DWELL_CYC + 1);
    localparam int RW = $clog2(LOCK_QUAL + 1);
    localparam int LW = $clog2(LOSS_CYC + 1);

    localparam logic [SW-1:0]       SETTLE_END = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0]       WIN_END    = DW'(DWELL_CYC - 1);
    localparam logic [RW-1:0]       RUN_QUAL   = RW'(LOCK_QUAL);
    localparam logic [LW-1:0]       LOSS_END   = LW'(LOSS_CYC);
    localparam logic [15:0]         SWEEP_MAX  = 16'(MAX_SWEEPS);
    localparam logic signed [7:0]   N_NEG      = 8'(-N_STEPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_TRACK,
        S_FAIL
    } state_t;

    state_t                r_state;
    logic [SW-1:0]         r_settleCnt;
    logic [DW-1:0]         r_winCnt;
    logic [RW-1:0]         r_runCnt;
    logic [LW-1:0]         r_lossCnt;
    logic [15:0]           r_sweepCnt;
    logic signed [7:0]     r_idx;
    logic [31:0]           r_phase;
    logic                  r_enable;
    logic                  r_acq;
    logic                  r_track;
    logic                  r_fail;

    logic [RW-1:0]         w_runNext;
    logic [LW-1:0]         w_lossNext;
    logic signed [7:0]     w_nextIdx;
    logic                  w_wrap;
    logic                  w_sweepLimit;

    // Sign-extend the index so negative points wrap correctly mod 2^32.
    function automatic logic [31:0] phaseOf(input logic signed [7:0] idx);
        logic [31:0] ext;
        ext = {{24{idx[7]}}, idx};
        return F_CENTER + ext * STEP_INC;
    endfunction

    // Sweep order 0, +1, -1, +2, -2 ... +N, -N, then back to 0.
    function automatic logic signed [7:0] nextIdxOf(input logic signed [7:0] idx);
        if (idx == 8'sd0)
            return 8'sd1;
        else if (!idx[7])
            return 8'sd0 - idx;
        else if (idx == N_NEG)
            return 8'sd0;
        else
            return (8'sd0 - idx) + 8'sd1;
    endfunction

    assign w_runNext    = acqBus.locked_i ? r_runCnt + 1'b1 : '0;
    assign w_lossNext   = acqBus.locked_i ? '0 : r_lossCnt + 1'b1;
    assign w_nextIdx    = nextIdxOf(r_idx);
    assign w_wrap       = (w_nextIdx == 8'sd0);
    assign w_sweepLimit = (MAX_SWEEPS != 0) && (r_sweepCnt + 16'd1 == SWEEP_MAX);

    // Single state machine; every output is a register updated with the state.
    always_ff @(posedge clk_main) begin
        if (rst || acqBus.abort_i) begin
            r_state     <= S_IDLE;
            r_settleCnt <= '0;
            r_winCnt    <= '0;
            r_runCnt    <= '0;
            r_lossCnt   <= '0;
            r_sweepCnt  <= '0;
            r_idx       <= '0;
            r_phase     <= F_CENTER;
            r_enable    <= 1'b0;
            r_acq       <= 1'b0;
            r_track     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FAIL: begin
                    if (acqBus.start_i) begin
                        r_state     <= S_SETTLE;
                        r_settleCnt <= '0;
                        r_sweepCnt  <= '0;
                        r_idx       <= '0;
                        r_phase     <= F_CENTER;
                        r_enable    <= 1'b1;
                        r_acq       <= 1'b1;
                        r_fail      <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (r_settleCnt == SETTLE_END) begin
                        r_state  <= S_DWELL;
                        r_winCnt <= '0;
                        r_runCnt <= '0;
                    end else begin
                        r_settleCnt <= r_settleCnt + 1'b1;
                    end
                end

                // Qualification wins over window expiry on the same cycle.
                S_DWELL: begin
                    r_runCnt <= w_runNext;
                    if (w_runNext == RUN_QUAL) begin
                        r_state   <= S_TRACK;
                        r_lossCnt <= '0;
                        r_acq     <= 1'b0;
                        r_track   <= 1'b1;
                    end else if (r_winCnt == WIN_END) begin
                        if (w_wrap && w_sweepLimit) begin
                            r_state  <= S_FAIL;
                            r_idx    <= '0;
                            r_phase  <= F_CENTER;
                            r_enable <= 1'b0;
                            r_acq    <= 1'b0;
                            r_fail   <= 1'b1;
                        end else begin
                            r_state     <= S_SETTLE;
                            r_settleCnt <= '0;
                            r_idx       <= w_nextIdx;
                            r_phase     <= phaseOf(w_nextIdx);
                            if (w_wrap)
                                r_sweepCnt <= r_sweepCnt + 16'd1;
                        end
                    end else begin
                        r_winCnt <= r_winCnt + 1'b1;
                    end
                end

                S_TRACK: begin
                    r_lossCnt <= w_lossNext;
                    if (w_lossNext == LOSS_END) begin
                        r_state     <= S_SETTLE;
                        r_settleCnt <= '0;
                        r_sweepCnt  <= '0;
                        r_idx       <= '0;
                        r_phase     <= F_CENTER;
                        r_acq       <= 1'b1;
                        r_track     <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_idx    <= '0;
                    r_phase  <= F_CENTER;
                    r_enable <= 1'b0;
                    r_acq    <= 1'b0;
                    r_track  <= 1'b0;
                    r_fail   <= 1'b0;
                end
            endcase
        end
    end

    assign acqBus.phase_nco_o = r_phase;
    assign acqBus.enable_o    = r_enable;
    assign acqBus.step_idx_o  = r_idx;
    assign acqBus.acq_o       = r_acq;
    assign acqBus.track_o     = r_track;
    assign acqBus.fail_o      = r_fail;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Self-checking bench for costas_acq_ctrl: directed scenarios plus randomized
// start/abort/lock traffic, compared every cycle against a point/timeline model.
module tb_costas_acq_ctrl;

    localparam logic [31:0] TB_F_CENTER = 32'h1000_0000;
    localparam logic [31:0] TB_STEP_INC = 32'h0010_0000;
    localparam int          TB_N        = 2;
    localparam int          TB_SETTLE   = 4;
    localparam int          TB_DWELL    = 8;
    localparam int          TB_QUAL     = 3;
    localparam int          TB_LOSS     = 5;
    localparam int          TB_MAXSW    = 2;
    localparam int          NPTS        = 2 * TB_N + 1;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_TRACK = 2;
    localparam int M_FAIL  = 3;

    logic clk;
    logic rst;

    costas_acq_ctrl_if acqBus ();
    costas_acq_ctrl_if wrapBus ();

    costas_acq_ctrl #(
        .F_CENTER(TB_F_CENTER), .STEP_INC(TB_STEP_INC), .N_STEPS(TB_N),
        .SETTLE_CYC(TB_SETTLE), .DWELL_CYC(TB_DWELL), .LOCK_QUAL(TB_QUAL),
        .LOSS_CYC(TB_LOSS), .MAX_SWEEPS(TB_MAXSW)
    ) dut (
        .clk_main(clk),
        .rst(rst),
        .acqBus(acqBus.slave)
    );

    costas_acq_ctrl #(
        .F_CENTER(32'hFFF0_0000), .STEP_INC(TB_STEP_INC), .N_STEPS(TB_N),
        .SETTLE_CYC(TB_SETTLE), .DWELL_CYC(TB_DWELL), .LOCK_QUAL(TB_QUAL),
        .LOSS_CYC(TB_LOSS), .MAX_SWEEPS(TB_MAXSW)
    ) dutWrap (
        .clk_main(clk),
        .rst(rst),
        .acqBus(wrapBus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount = 0;
    int totalCount = 0;

    // Model: mode, position in the sweep order, cycle index within the point
    // (settle occupies the first TB_SETTLE cycles), lock/loss runs, sweeps done.
    int order[NPTS];
    int mMode = M_IDLE;
    int mPos = 0;
    int mT = 0;
    int mOn = 0;
    int mOff = 0;
    int mSweeps = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic modelStep(input bit r, input bit s, input bit a, input bit l);
        if (r || a) begin
            mMode = M_IDLE; mPos = 0; mT = 0; mOn = 0; mOff = 0; mSweeps = 0;
        end else begin
            case (mMode)
                M_IDLE, M_FAIL: begin
                    if (s) begin
                        mMode = M_ACQ; mPos = 0; mT = 0; mOn = 0; mSweeps = 0;
                    end
                end
                M_ACQ: begin
                    if (mT < TB_SETTLE) begin
                        mT++;
                    end else begin
                        mOn = l ? mOn + 1 : 0;
                        if (mOn == TB_QUAL) begin
                            mMode = M_TRACK;
                            mOff = 0;
                        end else if (mT == TB_SETTLE + TB_DWELL - 1) begin
                            mPos++;
                            mT = 0;
                            mOn = 0;
                            if (mPos == NPTS) begin
                                mPos = 0;
                                mSweeps++;
                                if (mSweeps == TB_MAXSW) mMode = M_FAIL;
                            end
                        end else begin
                            mT++;
                        end
                    end
                end
                M_TRACK: begin
                    mOff = l ? 0 : mOff + 1;
                    if (mOff == TB_LOSS) begin
                        mMode = M_ACQ; mPos = 0; mT = 0; mOn = 0; mSweeps = 0;
                    end
                end
                default: mMode = M_IDLE;
            endcase
        end
    endtask

    task automatic compareModel();
        int          idx;
        logic [7:0]  idx8;
        logic [31:0] phase;
        bit          active;
        active = (mMode == M_ACQ) || (mMode == M_TRACK);
        idx    = active ? order[mPos] : 0;
        idx8   = 8'(idx);
        phase  = TB_F_CENTER + 32'(idx) * TB_STEP_INC;
        checkOutput("phase", acqBus.phase_nco_o, phase);
        checkOutput("enable", {31'b0, acqBus.enable_o}, {31'b0, active});
        checkOutput("stepIdx", {24'b0, acqBus.step_idx_o}, {24'b0, idx8});
        checkOutput("acq", {31'b0, acqBus.acq_o}, {31'b0, mMode == M_ACQ});
        checkOutput("track", {31'b0, acqBus.track_o}, {31'b0, mMode == M_TRACK});
        checkOutput("fail", {31'b0, acqBus.fail_o}, {31'b0, mMode == M_FAIL});
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit a, input bit l);
        rst             = r;
        acqBus.start_i  = s;
        acqBus.abort_i  = a;
        acqBus.locked_i = l;
        @(posedge clk);
        #1;
        modelStep(r, s, a, l);
        compareModel();
    endtask

    task automatic waitForPoint(input int pos, input int t);
        bit found;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (mMode == M_ACQ && mPos == pos && mT == t) begin
                found = 1;
                break;
            end
            applyStimulus(0, 0, 0, 0);
        end
        if (!found) checkOutput("waitTimeout", 32'd0, 32'd1);
    endtask

    task automatic enterTrackAtCentre();
        applyStimulus(0, 1, 0, 0);
        waitForPoint(0, TB_SETTLE);
        repeat (TB_QUAL) applyStimulus(0, 0, 0, 1);
        checkOutput("trackEntry", {31'b0, acqBus.track_o}, 32'd1);
    endtask

    initial begin
        bit          found;
        logic [31:0] wrapExp;
        int          bias;
        order[0] = 0;
        for (int k = 1; k <= TB_N; k++) begin
            order[2*k-1] = k;
            order[2*k]   = -k;
        end
        rst = 1'b1;
        acqBus.start_i = 0; acqBus.abort_i = 0; acqBus.locked_i = 0;
        wrapBus.start_i = 0; wrapBus.abort_i = 0; wrapBus.locked_i = 0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resetPhase", acqBus.phase_nco_o, 32'h1000_0000);
        checkOutput("resetEnable", {31'b0, acqBus.enable_o}, 32'd0);
        applyStimulus(0, 0, 0, 0);

        // Wrap-around: centre near the top of the 32-bit range.
        wrapBus.start_i = 1;
        applyStimulus(0, 0, 0, 0);
        wrapBus.start_i = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (wrapBus.step_idx_o == 8'd2) begin
                found = 1;
                break;
            end
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("wrapReached", {31'b0, found}, 32'd1);
        wrapExp = 32'hFFF0_0000 + 32'd2 * TB_STEP_INC;
        checkOutput("wrapPhase", wrapBus.phase_nco_o, wrapExp);
        wrapBus.abort_i = 1;
        applyStimulus(0, 0, 0, 0);
        wrapBus.abort_i = 0;

        // Full sweep without lock ends in FAIL after two sweeps.
        applyStimulus(0, 1, 0, 0);
        checkOutput("startAcq", {31'b0, acqBus.acq_o}, 32'd1);
        repeat (119) applyStimulus(0, 0, 0, 0);
        checkOutput("notYetFail", {31'b0, acqBus.fail_o}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("sweepFail", {31'b0, acqBus.fail_o}, 32'd1);
        checkOutput("failEnable", {31'b0, acqBus.enable_o}, 32'd0);

        // Acquire on point +2, lock from its 2nd dwell cycle.
        applyStimulus(0, 1, 0, 0);
        waitForPoint(3, TB_SETTLE);
        applyStimulus(0, 0, 0, 0);
        repeat (TB_QUAL) applyStimulus(0, 0, 0, 1);
        checkOutput("lateTrack", {31'b0, acqBus.track_o}, 32'd1);
        checkOutput("latePhase", acqBus.phase_nco_o, 32'h1020_0000);
        checkOutput("lateIdx", {24'b0, acqBus.step_idx_o}, 32'd2);

        // Broken qualification pattern 1,1,0,1,1,1.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        waitForPoint(0, TB_SETTLE);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("brokenNotYet", {31'b0, acqBus.track_o}, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("brokenTrack", {31'b0, acqBus.track_o}, 32'd1);

        // Qualification landing on the final dwell cycle.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        waitForPoint(0, TB_SETTLE + TB_DWELL - TB_QUAL);
        repeat (TB_QUAL) applyStimulus(0, 0, 0, 1);
        checkOutput("finalCycTrack", {31'b0, acqBus.track_o}, 32'd1);
        checkOutput("finalCycIdx", {24'b0, acqBus.step_idx_o}, 32'd0);

        // Loss of lock: four lows are tolerated, five re-acquire.
        repeat (TB_LOSS - 1) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lossHold", {31'b0, acqBus.track_o}, 32'd1);
        repeat (TB_LOSS) applyStimulus(0, 0, 0, 0);
        checkOutput("lossAcq", {31'b0, acqBus.acq_o}, 32'd1);
        checkOutput("lossPhase", acqBus.phase_nco_o, 32'h1000_0000);

        // Abort with start in the same dwell cycle.
        waitForPoint(0, TB_SETTLE + 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("abortEnable", {31'b0, acqBus.enable_o}, 32'd0);

        // Start ignored in TRACK, then reset from TRACK.
        enterTrackAtCentre();
        applyStimulus(0, 1, 0, 1);
        checkOutput("startInTrack", {31'b0, acqBus.track_o}, 32'd1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("rstTrack", {31'b0, acqBus.track_o}, 32'd0);
        checkOutput("rstPhase", acqBus.phase_nco_o, 32'h1000_0000);

        // Randomized traffic with a lock probability that changes per burst.
        for (int burst = 0; burst < 60; burst++) begin
            bias = $urandom_range(0, 3);
            for (int c = 0; c < 32; c++) begin
                bit r, s, a, l;
                r = ($urandom_range(0, 399) == 0);
                a = ($urandom_range(0, 59) == 0);
                s = ($urandom_range(0, 14) == 0);
                case (bias)
                    0: l = ($urandom_range(0, 9) == 0);
                    1: l = ($urandom_range(0, 1) == 0);
                    2: l = ($urandom_range(0, 9) != 0);
                    default: l = 1'b1;
                endcase
                applyStimulus(r, s, a, l);
            end
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/costas_acq_ctrl.md
# costas_acq_ctrl

Frequency-acquisition controller for the Costas carrier-recovery chain. It drives the NCO phase increment and enable of the Costas receiver top level. It sweeps the increment around a nominal carrier in fixed steps until the loop's `locked` flag qualifies, then holds that frequency while tracking. On sustained loss of lock it re-acquires, and after a bounded number of fruitless sweeps it reports failure.

## Interface
Parameters:
- `F_CENTER`, 32'h1000_0000: nominal phase increment (sweep point 0).
- `STEP_INC`, 32'h0010_0000: increment spacing between sweep points.
- `N_STEPS`, 4: points on each side of centre, 1..127; sweep has 2*N_STEPS+1 points.
- `SETTLE_CYC`, 300: cycles after a frequency change during which `locked_i` is ignored; covers FIR and loop latency. Must be ≥1.
- `DWELL_CYC`, 1024: observation window per sweep point. Must be ≥ LOCK_QUAL.
- `LOCK_QUAL`, 64: consecutive `locked_i`=1 cycles required to declare acquisition. Must be ≥1.
- `LOSS_CYC`, 256: consecutive `locked_i`=0 cycles in TRACK that declare loss. Must be ≥1.
- `MAX_SWEEPS`, 4: full sweeps before FAIL; 0 means unlimited.

Ports:
- `clk_main`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  pulse; begins acquisition from IDLE or FAIL.
- `abort_i`  in  1  pulse; returns to IDLE from any state.
- `locked_i`  in  1  lock flag from the Costas loop.
- `phase_nco_o`  out  32  phase increment to the NCO, registered.
- `enable_o`  out  1  NCO/datapath enable, registered.
- `step_idx_o`  out  8  signed index of the current sweep point.
- `acq_o`  out  1  high in SETTLE and DWELL.
- `track_o`  out  1  high in TRACK.
- `fail_o`  out  1  high in FAIL.

## Operation
- States: IDLE, SETTLE, DWELL, TRACK, FAIL.
- Sweep order is 0, +1, −1, +2, −2 … +N, −N, then back to 0.
- `phase_nco_o` = `F_CENTER` + `step_idx_o`*`STEP_INC`, computed mod 2^32. Wrap-around is legal and is not flagged.
- Each return to index 0 increments the sweep counter.
- IDLE: `enable_o`=0; `phase_nco_o`=`F_CENTER`; index 0.
  - `start_i` → SETTLE with index 0 and the sweep counter cleared.
- SETTLE: lasts exactly `SETTLE_CYC` cycles, then goes to DWELL. `locked_i` is ignored.
- DWELL: the window counter runs up to `DWELL_CYC`. The run counter counts consecutive `locked_i`=1 cycles and clears on any 0.
  - Run counter reaches `LOCK_QUAL` → TRACK.
  - Window expires without qualification → advance index → SETTLE.
  - If that advance completes sweep number `MAX_SWEEPS` (MAX_SWEEPS≠0) → FAIL instead.
- TRACK: the index is frozen. The loss counter counts consecutive `locked_i`=0 cycles and clears on 1.
  - Loss counter reaches `LOSS_CYC` → SETTLE with index 0 and the sweep counter cleared.
- FAIL: `enable_o`=0; `phase_nco_o`=`F_CENTER`; index 0.
  - `start_i` → SETTLE, same as from IDLE.
- `start_i` in SETTLE, DWELL or TRACK is ignored.
- `abort_i` beats every other event, including `start_i` in the same cycle.
- Priority within DWELL: qualification on the final window cycle → TRACK, not advance.
- `enable_o`=1 in SETTLE, DWELL and TRACK.

## Timing
- Reset values: state IDLE, `phase_nco_o`=`F_CENTER`, `enable_o`=0, `step_idx_o`=0, `acq_o`=`track_o`=`fail_o`=0. All counters are cleared.
- Reset mid-operation takes effect at the next edge.
- All outputs are registered and change on the same edge as the state.
- `start_i` sampled at edge t → at t+1 the state is SETTLE, with `enable_o`=1 and `acq_o`=1.
- A new `phase_nco_o` value appears on the same edge that enters SETTLE.
- SETTLE occupies exactly `SETTLE_CYC` cycles.
- DWELL occupies at most `DWELL_CYC` cycles.
- Minimum DWELL→TRACK latency is `LOCK_QUAL` cycles. The cycle after the qualifying sample shows `track_o`=1.
- TRACK→SETTLE occurs the cycle after the `LOSS_CYC`-th consecutive low sample.
- `abort_i` at edge t → at t+1 the state is IDLE and `enable_o`=0.

## Test plan
Defaults for all scenarios: F_CENTER=32'h1000_0000, STEP_INC=32'h0010_0000, N_STEPS=2, SETTLE_CYC=4, DWELL_CYC=8, LOCK_QUAL=3, LOSS_CYC=5, MAX_SWEEPS=2.

- **Sweep and fail.** `locked_i`=0 throughout, `start_i` pulse.
  - `phase_nco_o` steps 1000_0000, 1010_0000, 0FF0_0000, 1020_0000, 0FE0_0000, each held 12 cycles.
  - The sequence repeats once.
  - Then FAIL: `fail_o`=1, `enable_o`=0, 120 cycles after start.
- **Acquire on a late point.** `locked_i`=1 from the 2nd DWELL cycle of index +2.
  - TRACK is entered 3 cycles later with `phase_nco_o`=1020_0000 and `step_idx_o`=2.
- **Broken qualification and final-cycle priority.**
  - `locked_i` pattern 1,1,0,1,1,1 in DWELL → TRACK after the 6th cycle.
  - Qualifying on DWELL cycle 8 → TRACK, no advance.
- **Loss of lock.** In TRACK, `locked_i`=0 for 4 cycles then 1 → stays in TRACK.
  - `locked_i`=0 for 5 cycles → SETTLE with index 0 and `phase_nco_o`=1000_0000.
- **Abort and start handling.**
  - `abort_i`+`start_i` in the same DWELL cycle → IDLE next cycle.
  - `start_i` during TRACK → ignored.
  - `rst` asserted in TRACK → all outputs at reset values next cycle.
- **Wrap-around.** F_CENTER=32'hFFF0_0000, sweep point +2 → `phase_nco_o`=32'h0010_0000.
